// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage with synchronous write and asynchronous read
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count/status, sticky error flags, flush and selectable read mode
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 1024,
  parameter int AFULL_LVL = DEPTH - 4,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d, rdata;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             push_ok, pop_ok;
  assign empty       = count_q == '0;
  assign full        = count_q == CW'(DEPTH);
  assign almost_full = count_q >= CW'(AFULL_LVL);
  assign pop_ok      = pop & ~empty;
  assign push_ok     = push & (~full | pop_ok);
  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push_ok & ~clr),
    .waddr (tail_q),
    .wdata (din),
    .raddr (head_q),
    .rdata (rdata)
  );
  // next state: flush wins, otherwise pointers/count follow the accepted push and pop
  always_comb begin
    head_d  = clr ? '0 : head_q + AW'(pop_ok);
    tail_d  = clr ? '0 : tail_q + AW'(push_ok);
    count_d = clr ? '0 :
              (push_ok & ~pop_ok) ? count_q + 1'b1 :
              (pop_ok & ~push_ok) ? count_q - 1'b1 : count_q;
    ovf_d   = clr ? 1'b0 : ovf_q | (push & ~push_ok);
    udf_d   = clr ? 1'b0 : udf_q | (pop & empty);
    dout_d  = (~clr & pop_ok) ? rdata : dout_q;
  end
  // state registers with asynchronous reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end
  assign dout      = (FWFT != 0) ? rdata : dout_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench driving a registered-read and a fall-through FIFO in lockstep
module tb_sync_fifo;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       clr = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout0, dout1;
  logic       empty0, full0, af0, ovf0, udf0;
  logic       empty1, full1, af1, ovf1, udf1;
  logic [3:0] count0, count1;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] q[$];
  logic [7:0] mdout = '0;
  bit         movf = 1'b0;
  bit         mudf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(8), .DEPTH(8), .AFULL_LVL(6), .FWFT(0)) u0 (
    .clk(clk), .rstn(rstn), .clr(clr), .din(din), .push(push), .pop(pop),
    .dout(dout0), .empty(empty0), .full(full0), .almost_full(af0),
    .count(count0), .overflow(ovf0), .underflow(udf0)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(8), .AFULL_LVL(6), .FWFT(1)) u1 (
    .clk(clk), .rstn(rstn), .clr(clr), .din(din), .push(push), .pop(pop),
    .dout(dout1), .empty(empty1), .full(full1), .almost_full(af1),
    .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    int n = q.size();
    check("count", 32'(count0), 32'(n));
    check("empty", 32'(empty0), 32'(n == 0));
    check("full", 32'(full0), 32'(n == 8));
    check("almost_full", 32'(af0), 32'(n >= 6));
    check("overflow", 32'(ovf0), 32'(movf));
    check("underflow", 32'(udf0), 32'(mudf));
    check("dout", 32'(dout0), 32'(mdout));
    check("fwft_count", 32'(count1), 32'(n));
    check("fwft_empty", 32'(empty1), 32'(n == 0));
    check("fwft_ovf", 32'(ovf1), 32'(movf));
    check("fwft_udf", 32'(udf1), 32'(mudf));
    if (n > 0) check("fwft_dout", 32'(dout1), 32'(q[0]));
  endtask

  task automatic step(input bit pu, input bit po, input logic [7:0] d);
    int  n = q.size();
    bit  pok = po && n > 0;
    bit  puk = pu && (n < 8 || pok);
    push = pu;
    pop  = po;
    din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    if (pu && !puk) movf = 1'b1;
    if (po && n == 0) mudf = 1'b1;
    if (pok) mdout = q.pop_front();
    if (puk) q.push_back(d);
    compare_all();
  endtask

  task automatic flush();
    clr  = 1'b1;
    push = 1'b1;
    pop  = 1'b1;
    din  = 8'hEE;
    @(posedge clk);
    #1;
    clr  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    q.delete();
    movf = 1'b0;
    mudf = 1'b0;
    compare_all();
  endtask

  initial begin
    #3;
    rstn = 1'b0;
    #1;
    compare_all();
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) step(0, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(1, 0, 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h20 + 8'(i));
    for (int i = 0; i < 20; i++) step(1, 1, 8'h23 + 8'(i));
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00);
    flush();
    for (int i = 0; i < 8; i++) step(1, 0, 8'hA0 + 8'(i));
    step(1, 1, 8'hB0);
    check("full_pushpop_dout", 32'(dout0), 32'hA0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00);
    check("last_out", 32'(dout0), 32'hB0);
    step(0, 1, 8'h00);
    step(1, 1, 8'h77);
    flush();
    step(1, 0, 8'h55);
    check("fwft_first", 32'(dout1), 32'h55);
    step(1, 0, 8'h66);
    step(0, 1, 8'h00);
    check("fwft_second", 32'(dout1), 32'h66);
    step(0, 1, 8'h00);
    check("fwft_drained", 32'(empty1), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
